// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths, state encodings and port selects for mem_arbiter
package mem_arb_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      ARB_IDLE   = 3'd0,
      ARB_BUSY_I = 3'd1,
      ARB_BUSY_D = 3'd2,
      ARB_RESP_I = 3'd3,
      ARB_RESP_D = 3'd4
   } arb_state_t;

   localparam logic SEL_I = 1'b0;
   localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/arb_port_resp.sv
// rtl/arb_port_resp.sv - per-port read-data register and one-cycle ready pulse
module arb_port_resp
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              done,
   input  logic              rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] data_out,
   output logic              ready
);

   // data_out only moves on a completed read, so writes leave the last read value visible
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out <= '0;
         ready    <= 1'b0;
      end else begin
         ready <= done;
         if (done && rd)
            data_out <= mem_data;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one backing memory between imem and dmem ports, dmem priority with starvation guard
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 3,
   parameter int CNT_W        = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_req,
   input  logic              imem_wr,
   input  logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data_in,
   output logic [DATA_W-1:0] imem_data_out,
   output logic              imem_ready,
   input  logic              dmem_req,
   input  logic              dmem_wr,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_data_in,
   output logic [DATA_W-1:0] dmem_data_out,
   output logic              dmem_ready,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic              mem_ready
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_t       state;
   logic [CNT_W-1:0] starve_cnt;
   logic             grant_any;
   logic             grant_sel;
   logic             done_i;
   logic             done_d;

   always_comb begin
      grant_any = imem_req | dmem_req;
      if (imem_req && dmem_req)
         grant_sel = (starve_cnt == LIMIT) ? SEL_I : SEL_D;
      else
         grant_sel = dmem_req ? SEL_D : SEL_I;
   end

   assign done_i = (state == ARB_BUSY_I) && mem_ready;
   assign done_d = (state == ARB_BUSY_D) && mem_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ARB_IDLE;
         mem_req     <= 1'b0;
         mem_wr      <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         starve_cnt  <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grant_any && grant_sel == SEL_D) begin
                  state       <= ARB_BUSY_D;
                  mem_req     <= 1'b1;
                  mem_wr      <= dmem_wr;
                  mem_addr    <= dmem_addr;
                  mem_data_in <= dmem_data_in;
                  // only grants that actually bypass a waiting fetch count toward starvation
                  if (!imem_req)
                     starve_cnt <= '0;
                  else if (starve_cnt != LIMIT)
                     starve_cnt <= starve_cnt + 1'b1;
               end else if (grant_any) begin
                  state       <= ARB_BUSY_I;
                  mem_req     <= 1'b1;
                  mem_wr      <= imem_wr;
                  mem_addr    <= imem_addr;
                  mem_data_in <= imem_data_in;
                  starve_cnt  <= '0;
               end else begin
                  starve_cnt  <= '0;
               end
            end
            ARB_BUSY_I: begin
               if (mem_ready) begin
                  state   <= ARB_RESP_I;
                  mem_req <= 1'b0;
               end
            end
            ARB_BUSY_D: begin
               if (mem_ready) begin
                  state   <= ARB_RESP_D;
                  mem_req <= 1'b0;
               end
            end
            ARB_RESP_I, ARB_RESP_D: begin
               state <= ARB_IDLE;
            end
            default: begin
               state   <= ARB_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   arb_port_resp u_resp_i (
      .clk      (clk),
      .rst      (rst),
      .done     (done_i),
      .rd       (!mem_wr),
      .mem_data (mem_data_out),
      .data_out (imem_data_out),
      .ready    (imem_ready)
   );

   arb_port_resp u_resp_d (
      .clk      (clk),
      .rst      (rst),
      .done     (done_d),
      .rd       (!mem_wr),
      .mem_data (mem_data_out),
      .data_out (dmem_data_out),
      .ready    (dmem_ready)
   );

endmodule
